uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single `UART_TX` transmitter inside `UART` between `NUM_REQ` byte sources, such as a command responder, a debug logger and a status reporter. Each requester offers one byte at a time over a valid/ready handshake. The arbiter picks a winner round-robin, launches the byte into the transmitter, and waits for the frame to finish. A requester can hold the transmitter for a multi-byte packet so its bytes are never interleaved with another requester's.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: width of requester index; must equal clog2(`NUM_REQ`).

Ports:
- `clock`  in  1: the single system clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high; sampled on the rising edge of `clock`.
- `req_valid`  in  `NUM_REQ`: requester i has a byte on offer.
- `req_data`  in  8×`NUM_REQ`: packed bytes; requester i uses bits [8i+7:8i].
- `req_last`  in  `NUM_REQ`: the offered byte ends requester i's packet; 1 = release the lock after this byte.
- `req_ready`  out  `NUM_REQ`: one-hot or zero; the byte is accepted when valid&ready is high on a clock edge.
- `uart_tx_data`  out  8: connects to `tx_data` of `UART`.
- `uart_tx_ready`  out  1: one-cycle launch strobe; connects to `tx_ready`.
- `uart_tx_done`  in  1: connects to `tx_done` of `UART`.
- `busy`  out  1: high in any state other than IDLE.
- `grant_id`  out  `ID_W`: index of the last accepted requester.
- `locked`  out  1: a packet is in progress (last accepted byte had `req_last`=0).

## Operation
- The state machine has four states: IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - If unlocked, search `req_valid` starting at index `rr_ptr` and wrapping modulo `NUM_REQ`. The first set bit wins.
  - If locked, only requester `grant_id` is eligible. All other requesters are ignored even when valid.
  - `req_ready[winner]` is driven combinationally in IDLE only. It is never asserted to a requester whose `req_valid` is low.
  - On acceptance: latch the byte into `hold_data`, set `grant_id` to the winner, set `locked` to ~`req_last[winner]`, and go to LAUNCH.
  - If `req_last`=1 is accepted, set `rr_ptr` to (winner+1) mod `NUM_REQ`. Otherwise `rr_ptr` is unchanged.
- LAUNCH: `uart_tx_ready`=1 for exactly this cycle, with `uart_tx_data`=`hold_data`. Go to WAIT_LOW.
- WAIT_LOW: stay until `uart_tx_done`=0, then go to WAIT_HIGH.
- WAIT_HIGH: stay until `uart_tx_done`=1, then go to IDLE.
- Completion is therefore the first low-to-high transition of `tx_done` after launch. This works whether `tx_done` is an idle-level signal or an end-of-frame pulse.
- `uart_tx_data` holds `hold_data` continuously, not only during LAUNCH.
- A locked requester that drops `req_valid` stalls the arbiter in IDLE indefinitely. There is no timeout; the owner must finish its packet with `req_last`=1.
- Width rule: `rr_ptr` and `grant_id` are `ID_W` bits. Wrap-around is explicit modulo `NUM_REQ`, which need not be a power of 2.
- Reset mid-operation:
  - State returns to IDLE, `locked`=0, `rr_ptr`=0, and the held byte is discarded.
  - `UART` receives the same reset, so any in-flight frame is aborted there too.

## Timing
- Reset values: `req_ready`=0 (state is IDLE; driven immediately if a requester is valid after reset), `uart_tx_ready`=0, `uart_tx_data`=0x00, `busy`=0, `grant_id`=0, `locked`=0.
- Acceptance to launch: `uart_tx_ready` rises exactly 1 cycle after the accepting edge.
- Launch to next acceptance: 1 cycle after the edge where WAIT_HIGH sees `tx_done`=1.
- Throughput: one UART frame plus 3 cycles of overhead per byte.
- At most one `req_ready` bit is high in any cycle. `uart_tx_ready` is never high two cycles in a row.
- `req_valid` arriving during LAUNCH, WAIT_LOW or WAIT_HIGH is not acknowledged until IDLE. The requester must hold its data and valid until accepted.
- Simultaneous new valid and a lock release in the same IDLE cycle: the rotation starts from the updated `rr_ptr` on the next IDLE visit.

## Test plan
- Single byte: requester 2 offers 0x55 with last=1.
  - Required: `req_ready[2]` high 1 cycle, `uart_tx_ready` 1 cycle later with data 0x55, serial frame 0x55 on `tx`, `busy` back to 0 after `tx_done` rises.
- Round-robin: requesters 0, 1 and 3 all valid with last=1 from reset.
  - Required: service order 0, 1, 3, 0, ...; no requester served twice while another waits.
- Packet lock: requester 1 sends 0xA1, 0xA2, 0xA3 (last on 0xA3) while requester 0 is continuously valid.
  - Required: `tx` carries A1, A2, A3 consecutively, `locked`=1 until A3 is accepted, then requester 2/3/0 is served next.
- `tx_done` models: run the single-byte case with a level-type `tx_done` (high when idle) and with a pulse-type `tx_done`.
  - Required: exactly one `uart_tx_ready` per byte in both cases, and no early return to IDLE.
- Reset during WAIT_LOW with `locked`=1.
  - Required: next cycle all outputs equal their reset values, `rr_ptr`=0, and a fresh requester 3 byte is served normally.
- Locked stall: requester 0 accepts a byte with last=0, then drops valid for 50 cycles while requester 1 is valid.
  - Required: `req_ready[1]` stays 0, `busy`=0, `locked`=1, and service resumes on requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte sources.
// Supports packet locking so that a multi-byte packet from one source is never interleaved.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             uart_tx_data,
    output logic                   uart_tx_ready,
    input  logic                   uart_tx_done,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic                   locked
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_LOW,
        WAIT_HIGH
    } state_t;

    state_t          state_reg, state_next;
    logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0] grant_id_reg, grant_id_next;
    logic            locked_reg, locked_next;
    logic [7:0]      hold_data_reg, hold_data_next;

    logic [7:0]      req_byte [NUM_REQ];
    logic            found;
    logic [ID_W-1:0] winner;
    logic [ID_W:0]   cand;
    logic            accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_byte[gi]  = req_data[8*gi +: 8];
            assign req_ready[gi] = accept && (winner == ID_W'(gi));
        end
    endgenerate

    // Rotating priority search from rr_ptr; one extra bit lets the sum wrap for non-power-of-2 NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        if (locked_reg) begin
            winner = grant_id_reg;
            found  = req_valid[grant_id_reg];
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
                if (cand >= (ID_W+1)'(NUM_REQ)) begin
                    cand = cand - (ID_W+1)'(NUM_REQ);
                end
                if (!found && req_valid[cand[ID_W-1:0]]) begin
                    found  = 1'b1;
                    winner = cand[ID_W-1:0];
                end
            end
        end
    end

    assign accept = (state_reg == IDLE) && found;

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_id_next  = grant_id_reg;
        locked_next    = locked_reg;
        hold_data_next = hold_data_reg;
        uart_tx_ready  = 1'b0;
        busy           = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (found) begin
                    hold_data_next = req_byte[winner];
                    grant_id_next  = winner;
                    locked_next    = !req_last[winner];
                    if (req_last[winner]) begin
                        rr_ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
                    end
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                uart_tx_ready = 1'b1;
                state_next    = WAIT_LOW;
            end
            // Waiting for a low then a high catches both level-type and pulse-type done signals.
            WAIT_LOW: begin
                if (!uart_tx_done) begin
                    state_next = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (uart_tx_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_id_reg  <= '0;
            locked_reg    <= 1'b0;
            hold_data_reg <= 8'h00;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_id_reg  <= grant_id_next;
            locked_reg    <= locked_next;
            hold_data_reg <= hold_data_next;
        end
    end

    assign uart_tx_data = hold_data_reg;
    assign grant_id     = grant_id_reg;
    assign locked       = locked_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: byte-level reference model of the arbiter plus a UART done-signal emulator.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_valid, req_last, req_ready;
    logic [31:0]  req_data;
    logic [7:0]   uart_tx_data;
    logic         uart_tx_ready, uart_tx_done, busy, locked;
    logic [1:0]   grant_id;

    uart_tx_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready),
        .uart_tx_done(uart_tx_done),
        .busy(busy), .grant_id(grant_id), .locked(locked)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Requester queues: bit 8 = last flag, bits 7:0 = byte
    bit [8:0] q [N][$];
    bit       en [N];
    bit       acc_flag [N];
    int       log_id[$];
    int       log_data[$];

    // Reference model: byte in flight, launch pending, low seen, lock owner, rotation pointer
    bit       m_in_flight, m_launch, m_saw_low, m_locked;
    int       m_grant, m_ptr;
    bit [7:0] m_hold;

    // UART done emulator
    bit pulse_mode, rand_len, launch_seen, rst_seen;
    int frame_len, frame_left, launches;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(logic [3:0] v);
        if (m_locked) return v[m_grant[1:0]] ? m_grant : -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    // Compare process: check outputs against model, log handshakes, then advance model
    initial begin
        forever begin
            int w;
            logic [3:0] exp_ready;
            @(negedge clock);
            w = pick(req_valid);
            exp_ready = 4'b0;
            if (!m_in_flight && w >= 0) exp_ready[w[1:0]] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("uart_tx_ready", 32'(uart_tx_ready), 32'(m_in_flight && m_launch));
            check("uart_tx_data", 32'(uart_tx_data), 32'(m_hold));
            check("busy", 32'(busy), 32'(m_in_flight));
            check("grant_id", 32'(grant_id), 32'(m_grant));
            check("locked", 32'(locked), 32'(m_locked));

            launch_seen = uart_tx_ready;
            rst_seen    = reset;
            if (uart_tx_ready) launches++;
            for (int i = 0; i < N; i++) begin
                acc_flag[i] = !reset && req_valid[i] && req_ready[i];
                if (acc_flag[i]) begin
                    log_id.push_back(i);
                    log_data.push_back(int'(req_data[i*8 +: 8]));
                    $display("accept req=%0d data=0x%02h last=%0d t=%0t", i, req_data[i*8 +: 8], req_last[i], $time);
                end
            end

            if (reset) begin
                m_in_flight = 0; m_launch = 0; m_saw_low = 0; m_locked = 0;
                m_grant = 0; m_ptr = 0; m_hold = 8'h00;
            end else if (!m_in_flight) begin
                if (w >= 0) begin
                    m_hold      = req_data[w*8 +: 8];
                    m_grant     = w;
                    m_locked    = !req_last[w];
                    if (req_last[w]) m_ptr = (w + 1) % N;
                    m_in_flight = 1; m_launch = 1; m_saw_low = 0;
                end
            end else if (m_launch) begin
                m_launch = 0;
            end else if (!m_saw_low) begin
                if (!uart_tx_done) m_saw_low = 1;
            end else if (uart_tx_done) begin
                m_in_flight = 0;
            end
        end
    end

    // Requester driver and UART done emulator, both updated just after the rising edge
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rst_seen) begin
                frame_left   = 0;
                uart_tx_done = !pulse_mode;
            end else if (launch_seen) begin
                frame_left   = rand_len ? int'($urandom_range(1, 6)) : frame_len;
                uart_tx_done = 1'b0;
            end else if (frame_left > 1) begin
                frame_left--;
            end else if (frame_left == 1) begin
                frame_left   = 0;
                uart_tx_done = 1'b1;
            end else begin
                uart_tx_done = !pulse_mode;
            end
            for (int i = 0; i < N; i++) begin
                if (acc_flag[i] && q[i].size() > 0) void'(q[i].pop_front());
                acc_flag[i] = 0;
                if (en[i] && q[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[i*8 +: 8]  = q[i][0][7:0];
                    req_last[i]         = q[i][0][8];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[i*8 +: 8]  = 8'($urandom);
                    req_last[i]         = 1'($urandom);
                end
            end
        end
    end

    task automatic drain(int budget);
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 || m_in_flight || req_valid != 4'b0)
               && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain: still busy after %0d cycles, required idle", budget);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic wait_log(int target, int budget);
        int n = 0;
        while (log_id.size() < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_accept: %0d accepts, required %0d", log_id.size(), target);
        end
    endtask

    task automatic expect_acc(int idx, int id, int data);
        if (idx >= log_id.size()) begin
            checks++;
            errors++;
            $display("FAIL acc_missing[%0d]: only %0d accepts, required req=%0d data=0x%02h", idx, log_id.size(), id, data);
        end else begin
            check($sformatf("acc_id[%0d]", idx), 32'(log_id[idx]), 32'(id));
            check($sformatf("acc_data[%0d]", idx), 32'(log_data[idx]), 32'(data));
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, lc, n, r, pushed;
        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; uart_tx_done = 1'b1;
        for (int i = 0; i < N; i++) en[i] = 1;
        frame_len = 4; pulse_mode = 0; rand_len = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);

        // Reset values
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_tx_ready", 32'(uart_tx_ready), 32'h0);
        check("rst_tx_data", 32'(uart_tx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_grant", 32'(grant_id), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);

        // Single byte, level-type done then pulse-type done
        for (int mode = 0; mode < 2; mode++) begin
            pulse_mode = 1'(mode);
            repeat (3) @(negedge clock);
            base = log_id.size(); lc = launches;
            q[2].push_back({1'b1, 8'h55});
            drain(500);
            expect_acc(base, 2, 8'h55);
            check($sformatf("single_launches_mode%0d", mode), 32'(launches - lc), 32'd1);
            check($sformatf("single_busy_mode%0d", mode), 32'(busy), 32'h0);
        end
        pulse_mode = 0;
        repeat (3) @(negedge clock);

        // Round-robin from reset: 0,1,3,0,1,3
        do_reset();
        base = log_id.size();
        q[0].push_back({1'b1, 8'hB0}); q[0].push_back({1'b1, 8'hB1});
        q[1].push_back({1'b1, 8'hC0}); q[1].push_back({1'b1, 8'hC1});
        q[3].push_back({1'b1, 8'hD0}); q[3].push_back({1'b1, 8'hD1});
        drain(2000);
        expect_acc(base + 0, 0, 8'hB0);
        expect_acc(base + 1, 1, 8'hC0);
        expect_acc(base + 2, 3, 8'hD0);
        expect_acc(base + 3, 0, 8'hB1);
        expect_acc(base + 4, 1, 8'hC1);
        expect_acc(base + 5, 3, 8'hD1);

        // Packet lock: requester 1 holds the transmitter while requester 0 waits
        base = log_id.size();
        q[1].push_back({1'b0, 8'hA1}); q[1].push_back({1'b0, 8'hA2}); q[1].push_back({1'b1, 8'hA3});
        wait_log(base + 1, 200);
        q[0].push_back({1'b1, 8'hE0}); q[0].push_back({1'b1, 8'hE1}); q[0].push_back({1'b1, 8'hE2});
        drain(2000);
        expect_acc(base + 0, 1, 8'hA1);
        expect_acc(base + 1, 1, 8'hA2);
        expect_acc(base + 2, 1, 8'hA3);
        expect_acc(base + 3, 0, 8'hE0);
        expect_acc(base + 5, 0, 8'hE2);

        // Locked stall: owner 0 drops valid, requester 1 must not be served
        base = log_id.size();
        q[0].push_back({1'b0, 8'h01}); q[0].push_back({1'b1, 8'h02});
        wait_log(base + 1, 200);
        en[0] = 0;
        q[1].push_back({1'b1, 8'h10});
        n = 0;
        while (m_in_flight && n < 200) begin @(negedge clock); n++; end
        repeat (50) begin
            @(negedge clock);
            check("stall_ready1", 32'(req_ready[1]), 32'h0);
            check("stall_busy", 32'(busy), 32'h0);
            check("stall_locked", 32'(locked), 32'h1);
        end
        en[0] = 1;
        drain(1000);
        expect_acc(base + 1, 0, 8'h02);
        expect_acc(base + 2, 1, 8'h10);

        // Reset during WAIT_LOW while locked; pointer is 3 beforehand so the reset is visible in the order
        q[2].push_back({1'b1, 8'h2A});
        drain(500);
        frame_len = 8;
        q[1].push_back({1'b0, 8'h11}); q[1].push_back({1'b1, 8'h12});
        n = 0;
        while (!(uart_tx_ready && locked) && n < 200) begin @(negedge clock); n++; end
        check("rst_mid_launch_seen", 32'(uart_tx_ready && locked), 32'h1);
        en[1] = 0;
        q[1].delete();
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("rst_mid_pre_locked", 32'(locked), 32'h1);
        check("rst_mid_pre_busy", 32'(busy), 32'h1);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("rst_mid_tx_ready", 32'(uart_tx_ready), 32'h0);
        check("rst_mid_tx_data", 32'(uart_tx_data), 32'h00);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_grant", 32'(grant_id), 32'h0);
        check("rst_mid_locked", 32'(locked), 32'h0);
        en[1] = 1;
        frame_len = 4;
        base = log_id.size();
        q[2].push_back({1'b1, 8'h22}); q[3].push_back({1'b1, 8'h33});
        drain(500);
        expect_acc(base + 0, 2, 8'h22);
        expect_acc(base + 1, 3, 8'h33);

        // Randomized traffic with random frame lengths in both done styles
        rand_len = 1;
        for (int chunk = 0; chunk < 6; chunk++) begin
            pulse_mode = 1'(chunk % 2);
            repeat (3) @(negedge clock);
            base = log_id.size();
            pushed = 0;
            repeat (300) begin
                @(negedge clock);
                if ($urandom_range(0, 7) == 0) begin
                    r = int'($urandom_range(0, N - 1));
                    if (q[r].size() < 4) begin
                        n = int'($urandom_range(1, 3));
                        for (int j = 0; j < n; j++) begin
                            q[r].push_back({(j == n - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                        end
                        pushed += n;
                    end
                end
            end
            drain(4000);
            check($sformatf("rand_count[%0d]", chunk), 32'(log_id.size() - base), 32'(pushed));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
